// File: rtl/encoder_pkg.sv
// Shared widths, reset value and helper for the registered 8-to-3 priority encoder.
// Imported by the combinational priority stage and the registered top.
package encoder_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_OUT_W = 3;

  localparam logic [ENC_OUT_W-1:0] ENC_O_RST = 3'd0;

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  function automatic logic enc_is_multi(input logic [ENC_IN_W-1:0] req);
    return ((req & (req - 8'd1)) != 8'd0);
  endfunction

endpackage : encoder_pkg

// File: rtl/prio_enc_8to3.sv
// Combinational highest-index-wins 8-to-3 priority encoder.
// Produces the next-state code, valid and multi flags for the registered top.
module prio_enc_8to3
  import encoder_pkg::*;
(
  input  logic [ENC_IN_W-1:0]  i_req,
  output logic [ENC_OUT_W-1:0] o_code,
  output logic                 o_valid,
  output logic                 o_multi
);

  logic [ENC_OUT_W-1:0] w_code;

  // Descending-index priority select; all-zero falls to the reset code.
  always_comb begin
    w_code = ENC_O_RST;
    casez (i_req)
      8'b1???_????: w_code = 3'd7;
      8'b01??_????: w_code = 3'd6;
      8'b001?_????: w_code = 3'd5;
      8'b0001_????: w_code = 3'd4;
      8'b0000_1???: w_code = 3'd3;
      8'b0000_01??: w_code = 3'd2;
      8'b0000_001?: w_code = 3'd1;
      8'b0000_0001: w_code = 3'd0;
      default:      w_code = ENC_O_RST;
    endcase
  end

  assign o_code  = w_code;
  assign o_valid = (i_req != 8'd0);
  assign o_multi = enc_is_multi(i_req);

endmodule : prio_enc_8to3

// File: rtl/encoder_8_2_3.sv
// Registered 8-to-3 encoder: one-cycle latency, highest set bit wins,
// with valid (any request) and multi (not one-hot) flags.
module encoder_8_2_3
  import encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENC_IN_W-1:0]  i,
  output logic [ENC_OUT_W-1:0] O,
  output logic                 valid,
  output logic                 multi
);

  logic [ENC_OUT_W-1:0] w_code;
  logic                 w_valid;
  logic                 w_multi;

  logic [ENC_OUT_W-1:0] r_O;
  logic                 r_valid;
  logic                 r_multi;

  prio_enc_8to3 u_prio_enc (
    .i_req   (i),
    .o_code  (w_code),
    .o_valid (w_valid),
    .o_multi (w_multi)
  );

  // Output registers; reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_O     <= ENC_O_RST;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_O     <= w_code;
      r_valid <= w_valid;
      r_multi <= w_multi;
    end
  end

  assign O     = r_O;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule : encoder_8_2_3

// File: tb/tb_encoder_8_2_3.sv
// Self-checking bench for encoder_8_2_3: directed cases plus randomized
// back-to-back vectors checked against a bit-counting reference model.
module tb_encoder_8_2_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] i;
  logic [2:0] O;
  logic       valid;
  logic       multi;

  int tests_run    = 0;
  int tests_failed = 0;

  encoder_8_2_3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .O     (O),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan every bit, remember the highest set index and count set bits.
  function automatic logic [4:0] model(input logic [7:0] v);
    int hi  = 0;
    int cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) begin
        hi = k;
        cnt++;
      end
    end
    return {3'(hi), (cnt > 0), (cnt > 1)};
  endfunction

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got O=%0d valid=%0b multi=%0b, expected O=%0d valid=%0b multi=%0b",
               tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [4:0] outs();
    return {O, valid, multi};
  endfunction

  // Drive v at the falling edge, sample just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] v);
    @(negedge clk);
    i = v;
    @(posedge clk);
    #1;
    check_eq(tag, outs(), model(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int mode;

    // Reset held with all requests high: outputs stay cleared across edges.
    rst_n = 1'b0;
    i     = 8'hFF;
    #1;
    check_eq("reset_initial", outs(), 5'b000_0_0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq("reset_held", outs(), 5'b000_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot sweep, including the extreme codes 0 and 7.
    for (int k = 0; k < 8; k++) begin
      v = 8'd1 << k;
      step($sformatf("onehot_%0d", k), v);
      check_eq($sformatf("onehot_lit_%0d", k), outs(), {3'(k), 1'b1, 1'b0});
    end

    step("zero", 8'h00);
    check_eq("zero_lit", outs(), 5'b000_0_0);

    step("multi_24", 8'b0010_0100);
    check_eq("multi_24_lit", outs(), {3'd5, 1'b1, 1'b1});
    step("multi_ff", 8'hFF);
    check_eq("multi_ff_lit", outs(), {3'd7, 1'b1, 1'b1});
    step("multi_03", 8'h03);
    check_eq("multi_03_lit", outs(), {3'd1, 1'b1, 1'b1});

    // Hold between edges: a mid-cycle change of i must not reach the outputs.
    step("hold_08", 8'h08);
    @(negedge clk);
    i = 8'h40;
    #2;
    check_eq("hold_mid", outs(), {3'd3, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check_eq("hold_after", outs(), {3'd6, 1'b1, 1'b0});

    // Asynchronous reset between edges clears at once.
    step("pre_async", 8'h21);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", outs(), 5'b000_0_0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream with O=7 registered, then resume with 8'h10.
    step("pre_mid_7", 8'h80);
    check_eq("pre_mid_lit", outs(), {3'd7, 1'b1, 1'b0});
    i = 8'h10;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset_clear", outs(), 5'b000_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_reset_resume", outs(), {3'd4, 1'b1, 1'b0});

    // Randomized back-to-back vectors, biased toward zero and one-hot cases.
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       v = 8'h00;
        1:       v = 8'd1 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      step($sformatf("rand_%0d_%02h", n, v), v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_encoder_8_2_3

// File: doc/encoder_8_2_3.md
# encoder_8_2_3

Registered 8-to-3 binary encoder. Converts an 8-bit request vector into the 3-bit index of its asserted line, with highest-index priority when more than one line is set. Also flags the all-zero and multi-hot input cases. Sits between one-hot select/request sources and index-based consumers such as mux selects and address generators.

## Interface
Parameters:
- none (widths fixed: 8 inputs, 3-bit code)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i  input  8  request vector; bit k set means line k is requesting
- O  output  3  encoded index of the winning line
- valid  output  1  at least one bit of the sampled `i` was set
- multi  output  1  more than one bit of the sampled `i` was set (input was not one-hot)

## Operation
- Each rising edge of `clk` samples `i` and registers the results into `O`, `valid` and `multi`.
- Encoding for one-hot input: `i = 1 << k` gives `O = k` for k = 0..7, with `valid = 1` and `multi = 0`.
- Multi-hot input: `O` is the index of the highest set bit, with `valid = 1` and `multi = 1`.
- All-zero input: `O = 3'd0`, `valid = 0` and `multi = 0`.
- `O = 0` with `valid = 1` means bit 0 won. `O = 0` with `valid = 0` means no request.
- `multi` is computed as population count of `i` greater than 1, or an equivalent `i & (i - 1)` nonzero test.
- No internal state exists beyond the three output registers.

## Timing
- Latency: exactly 1 clock. Outputs reflect the `i` sampled at the previous rising edge.
- Throughput: one new input per cycle, with no stall or handshake.
- Reset: asserting `rst_n` low forces `O = 3'd0`, `valid = 0` and `multi = 0` immediately, with no clock required.
- Reset release: the first rising edge with `rst_n` high samples `i` normally.
- Reset mid-stream: any pending result is discarded, and outputs return to their reset values.
- `i` must be stable for setup/hold around the rising edge. There is no metastability protection; `i` is a synchronous input.
- Between edges, outputs hold their values regardless of changes on `i`.

## Structure
- Shared package `encoder_pkg` holds:
  - `ENC_IN_W = 8` and `ENC_OUT_W = 3`
  - the reset value constant `ENC_O_RST = 3'd0`
- One combinational sub-module, `prio_enc_8to3`, takes `i` and produces next-state `O`, `valid` and `multi`.
  - Written as a descending-index priority loop or case.
  - No clock or reset inside it.
- Top `encoder_8_2_3` instantiates `prio_enc_8to3` and holds the async-reset output flops.

## Test plan
- Reset: hold `rst_n = 0` with `i = 8'hFF` and toggle `clk`. Require `O = 0`, `valid = 0`, `multi = 0` throughout. Assert reset between clock edges and require the outputs to clear immediately.
- One-hot sweep: for k = 0..7 drive `i = 8'b1 << k` for one cycle each. After each edge require `O = k`, `valid = 1`, `multi = 0`, e.g. `i = 8'h01` gives `O = 0` and `i = 8'h80` gives `O = 7`.
- Zero input: `i = 8'h00` gives, one cycle later, `O = 0`, `valid = 0`, `multi = 0`.
- Multi-hot priority:
  - `i = 8'b0010_0100` gives `O = 5`, `valid = 1`, `multi = 1`.
  - `i = 8'hFF` gives `O = 7`, `multi = 1`.
  - `i = 8'h03` gives `O = 1`, `multi = 1`.
- Latency and hold:
  - Change `i` from `8'h08` to `8'h40` mid-cycle. `O` stays 3 until the next rising edge, then becomes 6.
  - Back-to-back changes every cycle track with exactly 1-cycle delay.
- Reset mid-stream: with `O = 7` registered, pulse `rst_n` low for half a cycle. Outputs clear at once. On the first edge after release with `i = 8'h10`, require `O = 4`, `valid = 1`.
